// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory access arbiter.
// Holds the transaction FSM encoding and the default access key.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WRITE,
        RD_WAIT,
        RESP
    } state_t;

    localparam int          DEF_ADDR_W     = 10;
    localparam int          DEF_DATA_W     = 32;
    localparam int          DEF_KEY_W      = 16;
    localparam logic [15:0] DEF_ACCESS_KEY = 16'h0032;

endpackage

// File: rtl/mem_access_arbiter_rr.sv
// Round-robin pick: first set request scanning upward from i_ptr with wrap.
// Purely combinational, zero latency; no backpressure (pointer lives in the parent).
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic             o_any
);

    logic [PTR_W:0] w_sum;

    always_comb begin
        o_gnt = '0;
        o_any = 1'b0;
        w_sum = '0;
        for (int k = 0; k < N; k++) begin
            // ptr < N and k < N, so one conditional subtract gives the modulo
            w_sum = {1'b0, i_ptr} + (PTR_W + 1)'(k);
            if (w_sum >= (PTR_W + 1)'(N)) begin
                w_sum = w_sum - (PTR_W + 1)'(N);
            end
            if (!o_any && i_req[w_sum[PTR_W-1:0]]) begin
                o_gnt[w_sum[PTR_W-1:0]] = 1'b1;
                o_any                   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Keyed round-robin master of the shared memory port; one transaction in flight (MEM_ARB_KEY_LOCKOUT_EN adds key-failure lockout).
// Accept->response: 3 cycles read/write, 2 cycles key error; requesters are held off via req_ready while busy.
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int              NUM_REQ    = 4,
    parameter int              ADDR_W     = DEF_ADDR_W,
    parameter int              DATA_W     = DEF_DATA_W,
    parameter int              KEY_W      = DEF_KEY_W,
    parameter logic [KEY_W-1:0] ACCESS_KEY = KEY_W'(DEF_ACCESS_KEY)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ-1:0]        i_req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_wdata,
    input  logic [NUM_REQ*KEY_W-1:0]  i_req_key,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    output logic                      o_rsp_err,
    output logic [DATA_W-1:0]         o_rsp_rdata,
    output logic                      o_mem_we,
    output logic [ADDR_W-1:0]         o_mem_waddr,
    output logic [DATA_W-1:0]         o_mem_wdata,
    output logic [ADDR_W-1:0]         o_mem_raddr,
    input  logic [DATA_W-1:0]         i_mem_rdata
`ifdef MEM_ARB_KEY_LOCKOUT_EN
    ,
    output logic [NUM_REQ-1:0]        o_lockout
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);

    state_t             r_state, w_next_state;
    logic [PTR_W-1:0]   r_rr_ptr, r_sel, w_gnt_idx;
    logic [ADDR_W-1:0]  r_addr, r_raddr_hold;
    logic [DATA_W-1:0]  r_wdata;
    logic [KEY_W-1:0]   r_key;
    logic               r_write;
    logic [NUM_REQ-1:0] w_elig, w_gnt;
    logic               w_any, w_key_ok, w_accept;

`ifdef MEM_ARB_KEY_LOCKOUT_EN
    logic [1:0]         r_fail_cnt [NUM_REQ];
    logic [NUM_REQ-1:0] w_locked;

    always_comb begin
        w_locked = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_locked[i] = (r_fail_cnt[i] == 2'd3);
        end
    end

    assign w_elig    = i_req_valid & ~w_locked;
    assign o_lockout = w_locked;

    // Saturates at 3, which locks the requester until the next reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_fail_cnt[i] <= 2'd0;
            end
        end else if (r_state == CHECK) begin
            if (w_key_ok) begin
                r_fail_cnt[r_sel] <= 2'd0;
            end else if (r_fail_cnt[r_sel] != 2'd3) begin
                r_fail_cnt[r_sel] <= r_fail_cnt[r_sel] + 2'd1;
            end
        end
    end
`else
    assign w_elig = i_req_valid;
`endif

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .i_req (w_elig),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_any (w_any)
    );

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_gnt_idx = PTR_W'(i);
            end
        end
    end

    assign w_accept = (r_state == IDLE) && w_any;
    assign w_key_ok = (r_key == ACCESS_KEY);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_req_ready  = '0;
        o_mem_raddr  = r_raddr_hold;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_next_state = CHECK;
                    // Gated by reset so an asserted req_valid cannot leak a grant
                    o_req_ready  = i_rst_n ? w_gnt : '0;
                end
            end
            CHECK: begin
                if (!w_key_ok) begin
                    w_next_state = RESP;
                end else if (r_write) begin
                    w_next_state = WRITE;
                end else begin
                    w_next_state = RD_WAIT;
                    o_mem_raddr  = r_addr;
                end
            end
            WRITE:   w_next_state = RESP;
            RD_WAIT: w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_ptr     <= '0;
            r_sel        <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_key        <= '0;
            r_write      <= 1'b0;
            r_raddr_hold <= '0;
            o_mem_we     <= 1'b0;
            o_mem_waddr  <= '0;
            o_mem_wdata  <= '0;
            o_rsp_valid  <= '0;
            o_rsp_err    <= 1'b0;
            o_rsp_rdata  <= '0;
        end else begin
            o_mem_we    <= 1'b0;
            o_rsp_valid <= '0;
            o_rsp_err   <= 1'b0;
            o_rsp_rdata <= '0;
            if (w_accept) begin
                r_sel    <= w_gnt_idx;
                r_rr_ptr <= (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
                r_write  <= i_req_write[w_gnt_idx];
                r_addr   <= i_req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
                r_wdata  <= i_req_wdata[w_gnt_idx*DATA_W +: DATA_W];
                r_key    <= i_req_key[w_gnt_idx*KEY_W +: KEY_W];
            end
            if (r_state == CHECK && w_key_ok) begin
                if (r_write) begin
                    o_mem_we    <= 1'b1;
                    o_mem_waddr <= r_addr;
                    o_mem_wdata <= r_wdata;
                end else begin
                    r_raddr_hold <= r_addr;
                end
            end
            // Response registers load on entry to RESP; only a CHECK->RESP hop is a key error
            if (w_next_state == RESP) begin
                o_rsp_valid <= NUM_REQ'(1) << r_sel;
                o_rsp_err   <= (r_state == CHECK);
                o_rsp_rdata <= (r_state == RD_WAIT) ? i_mem_rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Randomized scoreboard bench for mem_access_arbiter with a behavioural model and memory.
module tb_mem_access_arbiter;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int KW = 16;
    localparam logic [15:0] GOOD_KEY = 16'h0032;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0, req_write = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N*KW-1:0] req_key = '0;
    logic [N-1:0]    req_ready, rsp_valid;
    logic            rsp_err, mem_we;
    logic [DW-1:0]   rsp_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]   mem_waddr, mem_raddr;
`ifdef MEM_ARB_KEY_LOCKOUT_EN
    logic [N-1:0]    lockout;
`endif

    mem_access_arbiter #(.NUM_REQ(N)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_write (req_write),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .i_req_key   (req_key),
        .o_req_ready (req_ready),
        .o_rsp_valid (rsp_valid),
        .o_rsp_err   (rsp_err),
        .o_rsp_rdata (rsp_rdata),
        .o_mem_we    (mem_we),
        .o_mem_waddr (mem_waddr),
        .o_mem_wdata (mem_wdata),
        .o_mem_raddr (mem_raddr),
        .i_mem_rdata (mem_rdata)
`ifdef MEM_ARB_KEY_LOCKOUT_EN
        ,
        .o_lockout   (lockout)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(logic [9:0] a);
        return ({22'd0, a} * 32'h9E3779B1) ^ 32'h5A5A_5A5A;
    endfunction

    // Memory array: unwritten words read back as init_word(addr)
    bit [31:0] mem_arr [1024];
    bit        mem_wr  [1024];
    always @(posedge clk) begin
        if (mem_we) begin
            mem_arr[mem_waddr] <= mem_wdata;
            mem_wr[mem_waddr]  <= 1'b1;
        end
        mem_rdata <= mem_wr[mem_raddr] ? mem_arr[mem_raddr] : init_word(mem_raddr);
    end
    function automatic logic [31:0] mem_rd(logic [9:0] a);
        return mem_wr[a] ? mem_arr[a] : init_word(a);
    endfunction

    // Reference model state
    bit [31:0] shadow [1024];
    bit        sh_wr  [1024];
    function automatic logic [31:0] shadow_rd(logic [9:0] a);
        return sh_wr[a] ? shadow[a] : init_word(a);
    endfunction

    typedef struct {
        int          who;
        bit          err;
        logic [31:0] rdata;
        int          due;
        bit          wr;
        logic [9:0]  a;
        logic [31:0] d;
    } rsp_t;
    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
        int          due;
    } wr_t;

    rsp_t rsp_q[$];
    wr_t  wr_q[$];
    int   grants[$];
    int   ptr_m = 0;
    bit   busy  = 1'b0;
    int   lock_cnt [N];
    bit   acc_seen [N];
    int   last_who;
    logic last_err;
    logic [31:0] last_rdata;

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] locked_mask();
        logic [N-1:0] m = '0;
`ifdef MEM_ARB_KEY_LOCKOUT_EN
        for (int i = 0; i < N; i++) m[i] = (lock_cnt[i] >= 3);
`endif
        return m;
    endfunction

    // Round-robin rule: first pending requester at or after the pointer, wrapping
    function automatic int pick(logic [N-1:0] elig, int p);
        for (int k = 0; k < N; k++) begin
            if (elig[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_accept(int w);
        rsp_t r;
        logic [15:0] k = req_key[w*KW +: KW];
        r.who = w; r.wr = req_write[w]; r.a = req_addr[w*AW +: AW]; r.d = req_wdata[w*DW +: DW];
        r.rdata = '0;
        if (k != GOOD_KEY) begin
            r.err = 1'b1;
            r.due = cyc + 2;
            if (lock_cnt[w] < 3) lock_cnt[w]++;
        end else begin
            r.err = 1'b0;
            r.due = cyc + 3;
            lock_cnt[w] = 0;
            if (r.wr) wr_q.push_back('{a: r.a, d: r.d, due: cyc + 2});
            else      r.rdata = shadow_rd(r.a);
        end
        rsp_q.push_back(r);
        ptr_m = (w + 1) % N;
        busy  = 1'b1;
    endtask

    logic [N-1:0] m_elig;
    int           m_w;
    rsp_t         m_r;
    wr_t          m_wr;

    always @(negedge clk) begin
        if (rst_n) begin
`ifdef MEM_ARB_KEY_LOCKOUT_EN
            chk("lockout_port", lockout, locked_mask());
`endif
            m_elig = req_valid & ~locked_mask();
            if (!busy) begin
                m_w = pick(m_elig, ptr_m);
                chk("grant", req_ready, (m_w < 0) ? 4'b0 : (4'b0001 << m_w));
                if (m_w >= 0 && req_ready != 0) begin
                    for (int i = 0; i < N; i++) begin
                        if (req_ready[i]) begin
                            grants.push_back(i);
                            acc_seen[i] = 1'b1;
                        end
                    end
                    model_accept(m_w);
                end
            end else begin
                chk("ready_while_busy", req_ready, 0);
            end
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_mem_we", mem_we, 0);
                end else begin
                    m_wr = wr_q.pop_front();
                    chk("we_addr", mem_waddr, m_wr.a);
                    chk("we_data", mem_wdata, m_wr.d);
                    chk("we_cycle", cyc, m_wr.due);
                end
            end
            if (rsp_valid != 0) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", rsp_valid, 0);
                end else begin
                    m_r = rsp_q.pop_front();
                    chk("rsp_who", rsp_valid, 4'b0001 << m_r.who);
                    chk("rsp_err", rsp_err, m_r.err);
                    chk("rsp_rdata", rsp_rdata, m_r.rdata);
                    chk("rsp_latency", cyc, m_r.due);
                    if (m_r.wr && !m_r.err) begin
                        shadow[m_r.a] = m_r.d;
                        sh_wr[m_r.a]  = 1'b1;
                    end
                end
                for (int i = 0; i < N; i++) if (rsp_valid[i]) last_who = i;
                last_err   = rsp_err;
                last_rdata = rsp_rdata;
                busy = 1'b0;
            end
        end
    end

    task automatic set_req(int i, bit wr, logic [9:0] a, logic [31:0] d, logic [15:0] k);
        req_write[i]           = wr;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = d;
        req_key[i*KW +: KW]    = k;
    endtask

    task automatic rand_req(int i, logic [9:0] base, bit good_only);
        logic [15:0] k = GOOD_KEY;
        if (!good_only && $urandom_range(0, 99) < 20) k = GOOD_KEY ^ 16'($urandom_range(1, 65535));
        set_req(i, 1'($urandom_range(0, 1)), base + 10'($urandom_range(0, 15)), $urandom, k);
    endtask

    task automatic wait_acc(int r);
        for (int t = 0; t < 40 && !acc_seen[r]; t++) begin
            @(negedge clk); #1;
        end
        chk("accept_timeout", acc_seen[r], 1);
    endtask

    task automatic send(int r, bit wr, logic [9:0] a, logic [31:0] d, logic [15:0] k);
        @(posedge clk); #1;
        set_req(r, wr, a, d, k);
        acc_seen[r]  = 1'b0;
        req_valid[r] = 1'b1;
        wait_acc(r);
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
        acc_seen[r]  = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 100 && (busy || rsp_q.size() != 0 || wr_q.size() != 0); t++) begin
            @(negedge clk); #1;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        rsp_q.delete();
        wr_q.delete();
        busy  = 1'b0;
        ptr_m = 0;
        for (int i = 0; i < N; i++) begin
            lock_cnt[i] = 0;
            acc_seen[i] = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err",   rsp_err,   0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_mem_we",    mem_we,    0);
        chk("rst_mem_waddr", mem_waddr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_raddr", mem_raddr, 0);
`ifdef MEM_ARB_KEY_LOCKOUT_EN
        chk("rst_lockout",   lockout,   0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "global timeout");
    end

    initial begin
        int n0, n1;
        apply_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 10'(i), 32'h0, GOOD_KEY);
        req_valid = '1;
        repeat (3) @(posedge clk);
        #2;
        chk_reset_outputs();
        req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Write then read back through requester 0
        send(0, 1'b1, 10'h005, 32'hDEADBEEF, GOOD_KEY);
        wait_idle();
        send(0, 1'b0, 10'h005, 32'h0, GOOD_KEY);
        wait_idle();
        chk("wr_rd_data", last_rdata, 32'hDEADBEEF);
        chk("wr_rd_err", last_err, 0);

        // Bad key write from requester 2
        send(2, 1'b1, 10'h007, 32'h1234_5678, 16'h0031);
        wait_idle();
        chk("badkey_err", last_err, 1);
        chk("badkey_who", last_who, 2);
        chk("badkey_no_write", mem_rd(10'h007), init_word(10'h007));

        // Random traffic with occasional abandoned requests
        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && acc_seen[i]) begin
                    req_valid[i] = 1'b0;
                    acc_seen[i]  = 1'b0;
                end else if (!req_valid[i] && $urandom_range(0, 99) < 30) begin
                    rand_req(i, 10'h000, 1'b0);
                    req_valid[i] = 1'b1;
                end else if (req_valid[i] && $urandom_range(0, 99) < 3) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        for (int i = 0; i < N; i++) acc_seen[i] = 1'b0;
        wait_idle();

        // Reset during the CHECK cycle of a write, then full contention
        send(1, 1'b1, 10'h00A, 32'hA5A5_0F0F, GOOD_KEY);
        #1;
        apply_reset();
        #1;
        chk_reset_outputs();
        grants.delete();
        for (int i = 0; i < N; i++) rand_req(i, 10'h100, 1'b1);
        req_valid = '1;
        repeat (2) @(posedge clk);
        #2;
        chk_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int t = 0; t < 100 && grants.size() < 8; t++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (acc_seen[i]) begin
                    acc_seen[i] = 1'b0;
                    rand_req(i, 10'h100, 1'b1);
                end
            end
        end
        req_valid = '0;
        for (int i = 0; i < N; i++) acc_seen[i] = 1'b0;
        wait_idle();
        chk("contention_count", grants.size() >= 8, 1);
        for (int k = 0; k < 8 && k < grants.size(); k++) chk("contention_order", grants[k], k % N);
        chk("abort_no_write", mem_rd(10'h00A), shadow_rd(10'h00A));

`ifdef MEM_ARB_KEY_LOCKOUT_EN
        apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int r = 0; r < 3; r++) begin
            send(1, 1'b0, 10'h020, 32'h0, 16'h0031);
            wait_idle();
        end
        chk("lockout_set", lockout[1], 1);
        grants.delete();
        set_req(1, 1'b0, 10'h021, 32'h0, GOOD_KEY);
        req_valid[1] = 1'b1;
        for (int r = 0; r < 3; r++) begin
            send(0, 1'b0, 10'h030, 32'h0, GOOD_KEY);
            wait_idle();
        end
        repeat (10) @(posedge clk);
        req_valid = '0;
        n0 = 0;
        n1 = 0;
        foreach (grants[k]) begin
            if (grants[k] == 0) n0++;
            if (grants[k] == 1) n1++;
        end
        chk("locked_never_granted", n1, 0);
        chk("others_still_granted", n0, 3);
`endif

        wait_idle();
        chk("final_rsp_queue", rsp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Shares the single 32x1024 synchronous-read memory port set between NUM_REQ requesters.
- Each requester issues a keyed read or write.
- Round-robin selection among pending requesters; key compare against ACCESS_KEY; the memory write/read strobes are sequenced; one response is returned per transaction.
- Sits between the client blocks and the memory array; it is the only master of the memory ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 10, memory word address width
- DATA_W, 32, memory data width
- KEY_W, 16, access key width
- ACCESS_KEY, 16'h0032, key a request must present to touch memory

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  NUM_REQ  request pending, held until req_ready
- req_write  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*ADDR_W  per-requester address, packed, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  per-requester write data, packed
- req_key  in  NUM_REQ*KEY_W  per-requester key, packed
- req_ready  out  NUM_REQ  one-hot acceptance pulse
- rsp_valid  out  NUM_REQ  one-hot response pulse
- rsp_err  out  1  response is a key failure (qualified by any rsp_valid)
- rsp_rdata  out  DATA_W  read data (qualified by rsp_valid, read, no error)
- mem_we  out  1  memory write enable
- mem_waddr  out  ADDR_W  memory write address
- mem_wdata  out  DATA_W  memory write data
- mem_raddr  out  ADDR_W  memory read address
- mem_rdata  in  DATA_W  memory read data, registered, valid one cycle after mem_raddr

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0.
  - All outputs 0: req_ready, rsp_valid, rsp_err, rsp_rdata, mem_we, mem_waddr, mem_wdata, mem_raddr.
  - Reset mid-transaction aborts it: no response, no write.
- Request latching: a request is accepted on the cycle req_ready[i]=1. The arbiter latches addr, wdata, write and key in that cycle; the requester may drop or change its inputs afterwards.
- IDLE:
  - If any req_valid, pick the winner: the first set bit scanning from rr_ptr upward with wrap.
  - Pulse req_ready[winner] for 1 cycle, latch the fields, set rr_ptr=winner+1 mod NUM_REQ.
  - Go to CHECK.
- CHECK:
  - Key mismatch: go to RESP with err=1; no memory strobe.
  - Write: go to WRITE.
  - Read: drive mem_raddr=addr and go to RD_WAIT.
- WRITE: mem_we=1 for exactly this cycle with mem_waddr/mem_wdata = latched values; go to RESP.
- RD_WAIT: capture mem_rdata into the response register; go to RESP.
- RESP:
  - rsp_valid[winner]=1 for 1 cycle, with rsp_err and rsp_rdata.
  - rsp_rdata=0 on write or error.
  - Go to IDLE.
- Latency, accept to rsp_valid: read 3 cycles, write 3 cycles, key error 2 cycles. One transaction is outstanding at a time.
- Simultaneous requests: strict round-robin, so there is no starvation. With all NUM_REQ requesters valid continuously, the grant order is 0,1,2,3,0,...
- A req_valid dropped before acceptance is ignored, with no state change.
- mem_we is never asserted outside WRITE. mem_raddr holds its last value when idle.

Optional Feature:
- Macro: MEM_ARB_KEY_LOCKOUT_EN.
- Defined:
  - Per-requester 2-bit saturating fail counter, incremented on each key error and cleared on a successful key.
  - At count 3 the requester is locked: it is excluded from arbitration and its req_valid is ignored until rst_n.
  - Adds output lockout [NUM_REQ], reset 0.
- Undefined: no counters, no lockout port; key errors only produce the rsp_err response.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, CHECK, WRITE, RD_WAIT, RESP}
  - default ACCESS_KEY, ADDR_W, DATA_W and KEY_W constants
- Sub-module rr_arbiter (parameter N): inputs req[N], ptr; output one-hot gnt[N] and any. Purely combinational; rr_ptr is held in the parent.

Test Plan:
- Write then read:
  - Stimulus: req 0 writes addr 10'h005 data 32'hDEADBEEF key 16'h0032, then req 0 reads 10'h005.
  - Required: one-cycle mem_we pulse with waddr 005; read response rsp_rdata=32'hDEADBEEF, rsp_err=0, 3 cycles after accept.
- Bad key:
  - Stimulus: req 2 writes with key 16'h0031.
  - Required: mem_we stays 0; rsp_valid[2] with rsp_err=1, 2 cycles after accept.
- Contention:
  - Stimulus: all 4 req_valid held high for 8 grants.
  - Required: req_ready order 0,1,2,3,0,1,2,3; exactly one req_ready per transaction.
- Reset mid-write:
  - Stimulus: assert rst_n=0 in the CHECK cycle of a write.
  - Required: outputs 0 immediately, no mem_we pulse, next grant after release goes to req 0.
- Lockout (with MEM_ARB_KEY_LOCKOUT_EN):
  - Stimulus: req 1 sends 3 bad keys, then a good key.
  - Required: lockout[1]=1; the 4th request is never granted while other requesters still are.
